// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU memory port: one request at a time, served from BRAM or memory-mapped IO.
// Latency: rsp_valid 2 cycles after accept for stores and IO, RAM_LAT+2 cycles for RAM reads.
// Backpressure: req_ready is high only in IDLE; responses are single-cycle pulses with no backpressure.
module mem_io_responder #(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 16,
    parameter logic [ADDR_W-1:0] IO_BASE = 16'hFF00,
    parameter int                RAM_LAT = 1,
    parameter int                SW_W    = 10,
    parameter int                LED_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [SW_W-1:0]   sw_in,
    output logic [LED_W-1:0]  led_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [1:0]        LAT_LAST = 2'(RAM_LAT - 1);
    localparam logic [ADDR_W-1:0] OFF_LED  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] OFF_SW   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] OFF_TMR  = ADDR_W'(2);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [LED_W-1:0]    led_q, led_d;
    logic [DATA_W-1:0]   timer_q, timer_d;
    logic [SW_W-1:0]     sw_meta_q, sw_meta_d;
    logic [SW_W-1:0]     sw_sync_q, sw_sync_d;

    logic                is_io;
    logic [ADDR_W-1:0]   io_off;

    assign is_io  = (addr_q >= IO_BASE);
    assign io_off = addr_q - IO_BASE;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        led_d     = led_q;
        timer_d   = timer_q + DATA_W'(1);
        sw_meta_d = sw_in;
        sw_sync_d = sw_meta_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!is_io) begin
                    ram_en = 1'b1;
                    ram_we = we_q;
                    if (we_q) begin
                        rdata_d = '0;
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = S_WAIT;
                    end
                end else begin
                    // Response fields only change on entry to RESP so they hold between pulses.
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                    if (io_off == OFF_LED) begin
                        if (we_q) led_d = wdata_q[LED_W-1:0];
                        else      rdata_d = DATA_W'(led_q);
                    end else if (io_off == OFF_SW) begin
                        if (!we_q) rdata_d = DATA_W'(sw_sync_q);
                    end else if (io_off == OFF_TMR) begin
                        if (we_q) timer_d = wdata_q;
                        else      rdata_d = timer_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    rdata_d = ram_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= 2'd0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            led_q     <= '0;
            timer_q   <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            led_q     <= led_d;
            timer_q   <= timer_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign led_out   = led_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench: vector table driven through a request task, responses checked by a scoreboard monitor.
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr, ram_wdata;
    logic [15:0] ram_rdata;
    logic [9:0]  sw_in, led_out;

    always #5 clk = ~clk;

    mem_io_responder dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .sw_in(sw_in), .led_out(led_out)
    );

    // One-cycle-latency BRAM model
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [9:0]  sw;
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          lat;
    } vec_t;

    logic [15:0] tw_val = 16'h0;
    int          tw_cyc = 0;
    logic [9:0]  led_m  = 10'h0;

    always @(negedge clk) begin
        if (rsp_valid) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rsp cyc=%0d rdata=%h err=%b", cyc, rsp_rdata, rsp_err);
            end else begin
                e = sb.pop_front();
                if (rsp_rdata !== e.rdata || rsp_err !== e.err || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL rsp got rdata=%h err=%b cyc=%0d expected rdata=%h err=%b cyc=%0d",
                             rsp_rdata, rsp_err, cyc, e.rdata, e.err, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) chk("ready_timeout", {31'b0, req_ready}, 32'h1);
    endtask

    task automatic do_vec(input vec_t v);
        logic        is_ram;
        logic [15:0] exp_r;
        exp_t        e;
        int          n;
        sw_in = v.sw;
        repeat (4) @(negedge clk);
        wait_ready();
        is_ram = (v.addr < 16'hFF00);
        exp_r  = v.exp_rdata;
        if (!v.we && v.addr == 16'hFF02) exp_r = tw_val + 16'(cyc - tw_cyc);
        if (v.we && v.addr == 16'hFF02) begin
            tw_val = v.wdata;
            tw_cyc = cyc + 1;
        end
        e.rdata = exp_r; e.err = v.exp_err; e.cyc = cyc + v.lat;
        sb.push_back(e);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        chk("issue_ram_en", {31'b0, ram_en}, {31'b0, is_ram});
        chk("issue_ram_we", {31'b0, ram_we}, {31'b0, is_ram & v.we});
        if (is_ram) chk("issue_ram_addr", {16'b0, ram_addr}, {16'b0, v.addr});
        if (is_ram && v.we) chk("issue_ram_wdata", {16'b0, ram_wdata}, {16'b0, v.wdata});
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("rsp_timeout", sb.size(), 0);
            sb.delete();
        end
        if (v.we && v.addr == 16'hFF00) led_m = v.wdata[9:0];
        chk("led_out", {22'b0, led_out}, {22'b0, led_m});
    endtask

    vec_t vecs[19];

    initial begin
        vecs[0]  = '{1'b1, 16'h0010, 16'hBEEF, 10'h000, 16'h0000, 1'b0, 2};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 10'h000, 16'hBEEF, 1'b0, 3};
        vecs[2]  = '{1'b1, 16'h0011, 16'h1234, 10'h000, 16'h0000, 1'b0, 2};
        vecs[3]  = '{1'b0, 16'h0011, 16'h0000, 10'h000, 16'h1234, 1'b0, 3};
        vecs[4]  = '{1'b1, 16'hFEFF, 16'h5A5A, 10'h000, 16'h0000, 1'b0, 2};
        vecs[5]  = '{1'b0, 16'hFEFF, 16'h0000, 10'h000, 16'h5A5A, 1'b0, 3};
        vecs[6]  = '{1'b1, 16'hFF00, 16'hFFFF, 10'h000, 16'h0000, 1'b0, 2};
        vecs[7]  = '{1'b0, 16'hFF00, 16'h0000, 10'h000, 16'h03FF, 1'b0, 2};
        vecs[8]  = '{1'b0, 16'hFF01, 16'h0000, 10'h2A5, 16'h02A5, 1'b0, 2};
        vecs[9]  = '{1'b1, 16'hFF01, 16'h0000, 10'h2A5, 16'h0000, 1'b0, 2};
        vecs[10] = '{1'b0, 16'hFF00, 16'h0000, 10'h2A5, 16'h03FF, 1'b0, 2};
        vecs[11] = '{1'b1, 16'hFF00, 16'hA155, 10'h2A5, 16'h0000, 1'b0, 2};
        vecs[12] = '{1'b0, 16'hFF00, 16'h0000, 10'h2A5, 16'h0155, 1'b0, 2};
        vecs[13] = '{1'b1, 16'hFF02, 16'hFFFE, 10'h2A5, 16'h0000, 1'b0, 2};
        vecs[14] = '{1'b0, 16'hFF02, 16'h0000, 10'h2A5, 16'h0000, 1'b0, 2};
        vecs[15] = '{1'b0, 16'hFF07, 16'h0000, 10'h2A5, 16'h0000, 1'b1, 2};
        vecs[16] = '{1'b1, 16'hFF80, 16'h1111, 10'h2A5, 16'h0000, 1'b1, 2};
        vecs[17] = '{1'b0, 16'hFFFF, 16'h0000, 10'h2A5, 16'h0000, 1'b1, 2};
        vecs[18] = '{1'b0, 16'hFF01, 16'h0000, 10'h155, 16'h0155, 1'b0, 2};

        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; sw_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rdata_err", {15'b0, rsp_err, rsp_rdata}, 32'h0);
        chk("rst_ram", {14'b0, ram_en, ram_we, ram_addr}, 32'h0);
        chk("rst_ram_wdata", {16'b0, ram_wdata}, 32'h0);
        chk("rst_led", {22'b0, led_out}, 32'h0);
        reset = 1'b1;
        tw_val = 16'h0; tw_cyc = cyc - 1;

        // Timer read straight out of reset
        do_vec('{1'b0, 16'hFF02, 16'h0000, 10'h000, 16'h0000, 1'b0, 2});
        foreach (vecs[i]) do_vec(vecs[i]);

        // Reset while waiting on a BRAM read: transaction is dropped
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_issue_en_we", {30'b0, ram_en, ram_we}, 32'h2);
        @(negedge clk);
        chk("abort_in_wait", {30'b0, req_ready, rsp_valid}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rst_state", {30'b0, req_ready, rsp_valid}, 32'h2);
        chk("abort_rst_ram", {30'b0, ram_en, ram_we}, 32'h0);
        chk("abort_rst_led", {22'b0, led_out}, 32'h0);
        reset = 1'b1;
        tw_val = 16'h0; tw_cyc = cyc - 1; led_m = 10'h0;
        repeat (3) @(negedge clk);
        chk("abort_no_rsp", {31'b0, rsp_valid}, 32'h0);
        do_vec('{1'b0, 16'h0010, 16'h0000, 10'h000, 16'hBEEF, 1'b0, 3});
        do_vec('{1'b0, 16'hFF02, 16'h0000, 10'h000, 16'h0000, 1'b0, 2});
        do_vec('{1'b1, 16'h0020, 16'hC0DE, 10'h000, 16'h0000, 1'b0, 2});
        do_vec('{1'b0, 16'h0020, 16'h0000, 10'h000, 16'hC0DE, 1'b0, 3});

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
